// File: rtl/fir_pkg.sv
// Shared defaults and the loader state enumeration for the FIR coefficient loader.
package fir_pkg;

  localparam int TAPS_DEF = 25;
  localparam int DW_DEF   = 8;
  localparam int AW       = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLR    = 2'd1,
    ST_LOAD   = 2'd2,
    ST_STREAM = 2'd3
  } loader_state_e;

endpackage

// File: rtl/fir_coef_regfile.sv
// Coefficient storage: qualified write port, combinational load-read port and,
// with FIR_LOADER_READBACK_EN defined, a registered readback port.
module fir_coef_regfile
  import fir_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [DW-1:0] rd_coef
`ifdef FIR_LOADER_READBACK_EN
  ,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data
`endif
);

  logic [DW-1:0] coef_q [TAPS];

  // wr_en is already qualified by state and address range in the loader
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
    end else if (wr_en) begin
      coef_q[wr_addr] <= wr_data;
    end
  end

  assign rd_coef = coef_q[rd_idx];

`ifdef FIR_LOADER_READBACK_EN
  logic [DW-1:0] rb_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rb_q <= '0;
    end else begin
      rb_q <= (int'(rb_addr) < TAPS) ? coef_q[rb_addr] : '0;
    end
  end

  assign rb_data = rb_q;
`endif

endmodule

// File: rtl/fir_coef_loader.sv
// FIR coefficient loader: IDLE/CLR/LOAD/STREAM sequencer driving a shift-loaded filter.
// Optional macro FIR_LOADER_READBACK_EN adds the cfg_rdata readback port.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_wdata,
  output logic          cfg_err,
`ifdef FIR_LOADER_READBACK_EN
  output logic [DW-1:0] cfg_rdata,
`endif
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          done,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          fir_rst,
  output logic          load_c,
  output logic [DW-1:0] coef_in,
  output logic [DW-1:0] data_in,
  output loader_state_e dbg_state
);

  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  loader_state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, done_q, cfg_err_q, s_ready_q, fir_rst_q, load_c_q;
  logic [DW-1:0] coef_in_q, data_in_q, rd_coef;
  logic [AW-1:0] rd_idx;
  logic          cfg_open, addr_ok, wr_ok, wr_drop, start_take;

  assign cfg_open   = (state_q == ST_IDLE) || (state_q == ST_STREAM);
  assign addr_ok    = int'(cfg_addr) < TAPS;
  assign wr_ok      = cfg_we && cfg_open && addr_ok;
  assign wr_drop    = cfg_we && !wr_ok;
  assign start_take = start && cfg_open;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_CLR;
      ST_CLR: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
      end
      ST_LOAD: begin
        if (cnt_q == LAST) state_d = ST_STREAM;
        else               cnt_d   = cnt_q + 1'b1;
      end
      ST_STREAM: begin
        if (start)     state_d = ST_CLR;
        else if (stop) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Load cycle k presents coef[TAPS-1-k] so the last-shifted value lands in slot 0
  assign rd_idx = LAST - cnt_d;

  // Handshake: s_ready is high for every STREAM cycle and a sample is taken on each
  // such edge regardless of s_valid; data_in carries it (or 0 when !s_valid) next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      s_ready_q <= 1'b0;
      fir_rst_q <= 1'b0;
      load_c_q  <= 1'b0;
      coef_in_q <= '0;
      data_in_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= (state_d == ST_CLR) || (state_d == ST_LOAD);
      done_q    <= (state_d == ST_LOAD) && (cnt_d == LAST);
      s_ready_q <= (state_d == ST_STREAM);
      fir_rst_q <= (state_d == ST_CLR);
      load_c_q  <= (state_d == ST_LOAD);
      coef_in_q <= (state_d == ST_LOAD) ? rd_coef : '0;
      data_in_q <= ((state_q == ST_STREAM) && s_valid) ? s_data : '0;
      if (wr_drop)         cfg_err_q <= 1'b1;
      else if (start_take) cfg_err_q <= 1'b0;
    end
  end

  fir_coef_regfile #(.TAPS(TAPS), .DW(DW)) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_ok),
    .wr_addr (cfg_addr),
    .wr_data (cfg_wdata),
    .rd_idx  (rd_idx),
    .rd_coef (rd_coef)
`ifdef FIR_LOADER_READBACK_EN
    ,
    .rb_addr (cfg_addr),
    .rb_data (cfg_rdata)
`endif
  );

  assign cfg_err   = cfg_err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign s_ready   = s_ready_q;
  assign fir_rst   = fir_rst_q;
  assign load_c    = load_c_q;
  assign coef_in   = coef_in_q;
  assign data_in   = data_in_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: config/stream vector tables plus load, stop and reset sequences.
module tb_fir_coef_loader;
  import fir_pkg::*;

  localparam int TAPS = 25;
  localparam int DW   = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic          cfg_err;
`ifdef FIR_LOADER_READBACK_EN
  logic [DW-1:0] cfg_rdata;
`endif
  logic          start, stop, busy, done;
  logic          s_valid, s_ready, fir_rst, load_c;
  logic [DW-1:0] s_data, coef_in, data_in;
  loader_state_e dbg_state;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          err;
  } cfg_vec_t;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic [DW-1:0] e;
  } smp_vec_t;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] sq[$];
  logic [DW-1:0] mdl [TAPS];
  logic [DW-1:0] mon_e;
  cfg_vec_t      cfg_tbl [5];
  smp_vec_t      smp_tbl [6];
  int            checks = 0;
  int            errors = 0;
  bit            due = 1'b0;

  always #5 clk = ~clk;

  fir_coef_loader #(.TAPS(TAPS), .DW(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_err   (cfg_err),
`ifdef FIR_LOADER_READBACK_EN
    .cfg_rdata (cfg_rdata),
`endif
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .done      (done),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .fir_rst   (fir_rst),
    .load_c    (load_c),
    .coef_in   (coef_in),
    .data_in   (data_in),
    .dbg_state (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard: samples driven before an edge are due on the following negedge
  always @(posedge clk) due = (sq.size() > 0);

  always @(negedge clk) begin
    if (due) begin
      mon_e = sq.pop_front();
      chk("data_in", 32'(data_in), 32'(mon_e));
      due = 1'b0;
    end
    if (load_c) begin
      if (exp_q.size() == 0) begin
        chk("load_c_unexpected", 32'(load_c), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("coef_in", 32'(coef_in), 32'(mon_e));
      end
    end
  end

  task automatic drive_sample(input logic v, input logic [DW-1:0] d, input logic [DW-1:0] e);
    s_valid = v;
    s_data  = d;
    sq.push_back(e);
    tick();
  endtask

  // Called at a negedge in IDLE or STREAM; returns at the first STREAM negedge.
  task automatic do_start(input logic with_stop);
    start = 1'b1;
    stop  = with_stop;
    for (int j = 0; j < TAPS; j++) exp_q.push_back(mdl[TAPS-1-j]);
    tick();
    chk("clr_state", 32'(dbg_state), 32'(ST_CLR));
    chk("clr_fir_rst", 32'(fir_rst), 32'd1);
    chk("clr_busy", 32'(busy), 32'd1);
    chk("clr_load_c", 32'(load_c), 32'd0);
    chk("clr_cfg_err", 32'(cfg_err), 32'd0);
    start = 1'b0;
    stop  = 1'b1;
    for (int k = 0; k < TAPS; k++) begin
      tick();
      chk("load_state", 32'(dbg_state), 32'(ST_LOAD));
      chk("load_busy", 32'(busy), 32'd1);
      chk("load_fir_rst", 32'(fir_rst), 32'd0);
      chk("load_done", 32'(done), (k == TAPS - 1) ? 32'd1 : 32'd0);
      if (k == 6) chk("load_cfg_err", 32'(cfg_err), 32'd1);
      stop      = 1'b0;
      start     = (k == 3);
      cfg_we    = (k == 5);
      cfg_addr  = 5'd2;
      cfg_wdata = 8'h99;
    end
    start  = 1'b0;
    cfg_we = 1'b0;
    tick();
    chk("stream_state", 32'(dbg_state), 32'(ST_STREAM));
    chk("stream_s_ready", 32'(s_ready), 32'd1);
    chk("stream_busy", 32'(busy), 32'd0);
    chk("stream_done", 32'(done), 32'd0);
    chk("stream_load_c", 32'(load_c), 32'd0);
    chk("load_count", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic stop_seq();
    stop = 1'b1;
    drive_sample(1'b1, 8'h5A, 8'h5A);
    chk("stop_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("stop_s_ready", 32'(s_ready), 32'd0);
    stop    = 1'b0;
    s_valid = 1'b0;
    tick();
    chk("idle_data_in", 32'(data_in), 32'd0);
  endtask

  initial begin
    cfg_tbl[0] = '{5'd0,  8'h01, 1'b0};
    cfg_tbl[1] = '{5'd24, 8'h19, 1'b0};
    cfg_tbl[2] = '{5'd25, 8'h33, 1'b1};
    cfg_tbl[3] = '{5'd31, 8'h44, 1'b1};
    cfg_tbl[4] = '{5'd12, 8'h0D, 1'b1};
    smp_tbl[0] = '{1'b1, 8'h10, 8'h10};
    smp_tbl[1] = '{1'b0, 8'h77, 8'h00};
    smp_tbl[2] = '{1'b1, 8'hFF, 8'hFF};
    smp_tbl[3] = '{1'b1, 8'h00, 8'h00};
    smp_tbl[4] = '{1'b0, 8'hFF, 8'h00};
    smp_tbl[5] = '{1'b1, 8'h81, 8'h81};

    reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0;
    for (int j = 0; j < TAPS; j++) mdl[j] = '0;
    tick();
    tick();
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_fir_rst", 32'(fir_rst), 32'd0);
    chk("rst_load_c", 32'(load_c), 32'd0);
    chk("rst_coef_in", 32'(coef_in), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    reset_n = 1'b1;
    tick();

    for (int j = 0; j < TAPS; j++) begin
      cfg_we = 1'b1; cfg_addr = AW'(j); cfg_wdata = DW'(j + 1);
      mdl[j] = DW'(j + 1);
      tick();
    end
    cfg_we = 1'b0;
    chk("wr_cfg_err", 32'(cfg_err), 32'd0);

    for (int i = 0; i < 5; i++) begin
      cfg_we = 1'b1; cfg_addr = cfg_tbl[i].a; cfg_wdata = cfg_tbl[i].d;
      tick();
      cfg_we = 1'b0;
      if (int'(cfg_tbl[i].a) < TAPS) mdl[cfg_tbl[i].a] = cfg_tbl[i].d;
      chk("tbl_cfg_err", 32'(cfg_err), 32'(cfg_tbl[i].err));
    end

`ifdef FIR_LOADER_READBACK_EN
    cfg_we = 1'b1; cfg_addr = 5'd3; cfg_wdata = 8'hA5;
    mdl[3] = 8'hA5;
    tick();
    cfg_we = 1'b0;
    tick();
    chk("rb_slot3", 32'(cfg_rdata), 32'h0A5);
    cfg_addr = 5'd30;
    tick();
    chk("rb_slot30", 32'(cfg_rdata), 32'd0);
`endif

    do_start(1'b0);
    for (int i = 0; i < 6; i++) drive_sample(smp_tbl[i].v, smp_tbl[i].d, smp_tbl[i].e);
    s_valid = 1'b0;

    for (int j = 0; j < TAPS; j++) begin
      cfg_we = 1'b1; cfg_addr = AW'(j); cfg_wdata = (j == 0) ? 8'h80 : 8'h00;
      mdl[j] = cfg_wdata;
      tick();
    end
    cfg_we = 1'b0;
    chk("stream_wr_load_c", 32'(load_c), 32'd0);
    chk("stream_wr_coef_in", 32'(coef_in), 32'd0);
    chk("stream_wr_state", 32'(dbg_state), 32'(ST_STREAM));

    do_start(1'b1);
    for (int i = 0; i < 30; i++) drive_sample(1'b1, 8'h10, 8'h10);
    for (int i = 0; i < 3; i++) drive_sample(1'b0, 8'h10, 8'h00);
    stop_seq();

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 11; j++) exp_q.push_back(mdl[TAPS-1-j]);
    for (int k = 0; k <= 10; k++) tick();
    #1 reset_n = 1'b0;
    #1;
    chk("arst_load_c", 32'(load_c), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("arst_coef_in", 32'(coef_in), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_load_count", 32'(exp_q.size()), 32'd0);
    for (int j = 0; j < TAPS; j++) mdl[j] = '0;
    tick();
    #1 reset_n = 1'b1;
    tick();
`ifdef FIR_LOADER_READBACK_EN
    cfg_addr = 5'd0;
    tick();
    tick();
    chk("arst_rb_slot0", 32'(cfg_rdata), 32'd0);
`endif
    do_start(1'b0);
    drive_sample(1'b1, 8'h3C, 8'h3C);
    stop_seq();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fir_coef_loader.md
FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

Interface
REQ-001 Parameter TAPS, default 25, number of filter taps and coefficient slots SHALL be TAPS.
REQ-002 Parameter DW, default 8, sample and coefficient width SHALL be DW.
REQ-003 Port clk, in, 1: single clock; all logic SHALL be rising-edge.
REQ-004 Port reset_n, in, 1: reset SHALL be asynchronous and active-low.
REQ-005 Port cfg_we, in, 1: coefficient write strobe.
REQ-006 Port cfg_addr, in, 5: coefficient slot index.
REQ-007 Port cfg_wdata, in, DW: coefficient value.
REQ-008 Port cfg_err, out, 1: sticky flag for a dropped write; cleared by reset or start.
REQ-009 Port start, in, 1: one-cycle request to clear the filter, load it, then stream.
REQ-010 Port stop, in, 1: return to IDLE from STREAM.
REQ-011 Port busy, out, 1: high in CLR and LOAD.
REQ-012 Port done, out, 1: one-cycle pulse when loading completes.
REQ-013 Port s_valid, in, 1: sample available.
REQ-014 Port s_data, in, DW: sample value.
REQ-015 Port s_ready, out, 1: sample accepted this cycle.
REQ-016 Port fir_rst, out, 1: active-high synchronous reset to the filter.
REQ-017 Port load_c, out, 1: filter coefficient-shift enable.
REQ-018 Port coef_in, out, DW: coefficient to the filter.
REQ-019 Port data_in, out, DW: sample to the filter.

Function
REQ-020 States SHALL be IDLE, CLR, LOAD and STREAM; all filter-side outputs SHALL be registered.
REQ-021 IDLE: start -> CLR; all other inputs are ignored.
REQ-022 CLR SHALL last exactly 1 cycle with fir_rst=1, then go to LOAD.
REQ-023 LOAD SHALL last exactly TAPS cycles with load_c=1; cycle k (0..TAPS-1) drives coef_in = coef[TAPS-1-k], so filter slot j ends holding coef[j].
REQ-024 On the last LOAD cycle the block SHALL assert done for one cycle and go to STREAM.
REQ-025 STREAM: s_ready=1; data_in = s_data when s_valid, else 0 (zero-insertion keeps the filter's per-cycle shift aligned).
REQ-026 Outside STREAM: s_ready=0, data_in=0, load_c=0 except in LOAD, and coef_in=0 except in LOAD.
REQ-027 STREAM with stop=1 -> IDLE; STREAM with start=1 -> CLR; start has priority when both are asserted.
REQ-028 start or stop during CLR or LOAD SHALL be ignored.
REQ-029 A cfg_we in IDLE or STREAM with cfg_addr<TAPS SHALL write coef[cfg_addr] at the clock edge.
REQ-030 A cfg_we during CLR or LOAD, or with cfg_addr>=TAPS, SHALL be dropped and SHALL set cfg_err.
REQ-031 A write in STREAM SHALL NOT affect the filter until the next start.
REQ-032 The LOAD counter SHALL count 0..TAPS-1 without wrap and SHALL reset to 0 on entry to LOAD.

Reset
REQ-033 Assertion of reset_n SHALL asynchronously force state=IDLE, all coef=0, and busy, done, cfg_err, s_ready, fir_rst, load_c, coef_in and data_in all 0.
REQ-034 Reset during LOAD SHALL abandon the sequence; the filter contents are then undefined until the next start.

Configuration
REQ-035 With FIR_LOADER_READBACK_EN defined, the block SHALL add port cfg_rdata (out, DW) equal to coef[cfg_addr] registered with 1-cycle latency, or 0 when cfg_addr>=TAPS.
REQ-036 Without FIR_LOADER_READBACK_EN, the cfg_rdata port and its logic SHALL be absent.

Structure
REQ-037 A shared package fir_pkg SHALL hold the TAPS and DW defaults and the loader state enumeration.
REQ-038 The coefficient storage and write/readback logic SHALL be a sub-module fir_coef_regfile; the FSM and counter SHALL stay in fir_coef_loader.

Verification
REQ-039 Write coef[j]=j+1 for j=0..24, pulse start -> 1 cycle of fir_rst, then 25 cycles of load_c with coef_in 25,24,...,1, then done pulse; a connected filter holds slot j=j+1.
REQ-040 In STREAM, s_valid=1 with s_data=0x10 for 30 cycles after loading coef[0]=0x80 and all others 0 -> data_in=0x10 each cycle; s_valid=0 -> data_in=0x00.
REQ-041 cfg_we during LOAD, or with cfg_addr=25 -> no write and cfg_err=1; the next start clears cfg_err.
REQ-042 start and stop asserted together in STREAM -> CLR; stop alone -> IDLE with s_ready=0 the next cycle.
REQ-043 reset_n low at LOAD cycle 10 -> immediately load_c=0, busy=0, state IDLE, and coefficients read back as 0.
REQ-044 With FIR_LOADER_READBACK_EN: write 0xA5 to slot 3, then read slot 3 -> cfg_rdata=0xA5 one cycle later; slot 30 -> cfg_rdata=0.
